divsqrt_rr_arbiter: RTL and testbench
=====================================

# divsqrt_rr_arbiter

Shares one iterative divide/square-root unit between two requesters. Each requester gets a tagged request/response interface, with round-robin arbitration and at most one operation in flight. The block sits between two FPU issue ports and the shared DivSqrtRecFN_small_1 instance. It drives the unit's input handshake and captures its single-cycle result pulse into a held response register, because the unit has no output backpressure.

## Interface
Parameters:
- TAG_W, default 5: width of the requester-supplied tag returned with each result.
- WD_LIMIT, default 255: watchdog threshold in cycles. Used only with DIVSQRT_ARB_WATCHDOG_EN.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_reqN_valid / io_reqN_ready  in/out  1  request handshake, N = 0, 1.
- io_reqN_sqrtOp  in  1  1 = sqrt, 0 = divide.
- io_reqN_a, io_reqN_b  in  65  recoded FP64 operands.
- io_reqN_roundingMode  in  3  rounding mode.
- io_reqN_tag  in  TAG_W  opaque tag.
- io_du_inReady  in  1  unit ready.
- io_du_inValid  out  1  issue strobe to the unit.
- io_du_sqrtOp, io_du_a, io_du_b, io_du_roundingMode  out  1/65/65/3  muxed operands.
- io_du_outValid_div, io_du_outValid_sqrt  in  1  unit result pulses.
- io_du_out  in  65  result.
- io_du_exceptionFlags  in  5  flags.
- io_resp_valid / io_resp_ready  out/in  1  response handshake.
- io_resp_id  out  1  requester that owns the result.
- io_resp_tag  out  TAG_W  echoed tag.
- io_resp_out  out  65  result.
- io_resp_flags  out  5  exception flags.
- io_resp_sqrt  out  1  1 if the result came from the sqrt pulse.
- io_kill  in  1  abort the in-flight or held operation.
- io_wdError  out  1  sticky watchdog error. Constant 0 without the macro.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset enters IDLE.
- IDLE:
  - Grant goes to the valid requester. If both requesters are valid, grant goes to the one not granted last.
  - The priority pointer resets to favour req0.
  - io_du_inValid = any request valid. Operands are muxed from the granted requester.
  - io_reqN_ready = granted_N & io_du_inReady.
  - On accept (ready & valid): latch id and tag, flip the pointer to the other requester, and go to BUSY.
- BUSY:
  - io_du_inValid = 0 and both io_reqN_ready = 0.
  - On io_du_outValid_div | io_du_outValid_sqrt: capture out, flags, and sqrt (= outValid_sqrt) into the response register, then go to RESP.
  - If the drop flag is set, discard the pulse instead and go to IDLE.
- RESP:
  - io_resp_valid = 1. Outputs stay stable until io_resp_ready, then go to IDLE.
  - No new grant occurs while the response is held.
- Kill:
  - io_kill in BUSY sets the drop flag.
  - io_kill in RESP clears io_resp_valid next cycle and returns to IDLE.
  - io_kill in IDLE has no effect.
  - The drop flag clears on entry to IDLE.
- Result pulses outside BUSY are ignored.

## Timing
- Reset values:
  - io_resp_valid, io_resp_id, io_resp_tag, io_resp_out, io_resp_flags, io_resp_sqrt = 0.
  - io_wdError = 0; pointer = 0; state = IDLE.
  - io_du_inValid and io_reqN_ready are combinational and read 0 only if no request is valid.
- Accept occurs at cycle t. BUSY holds from t+1. A result pulse at cycle u makes io_resp_valid high at u+1.
- Latency = unit latency + 1 cycle.
- Minimum accept-to-accept spacing: return to IDLE on the cycle after the response handshake, so the next accept is possible at the earliest 2 cycles after the result pulse.
- Result pulse and io_kill in the same BUSY cycle: the result is dropped and the FSM goes to IDLE.
- io_resp_ready and io_kill in the same RESP cycle: go to IDLE. The handshake counts as completed.
- Reset mid-operation clears the FSM and response register. The unit shares reset, so no stale pulse can arrive.

## Configuration
- DIVSQRT_ARB_WATCHDOG_EN defined:
  - An 8-bit-minimum counter increments each BUSY cycle and clears on leaving BUSY.
  - Reaching WD_LIMIT sets io_wdError (sticky until reset) and forces the FSM to IDLE with the drop flag set.
- Macro undefined: no counter, and io_wdError is tied to 0.

## Test plan
- req0 only: div, a = 6.0, b = 3.0, tag 0x03 -> accepted, io_du_inValid for 1 cycle. io_resp_valid 1 cycle after outValid_div, with id 0, tag 0x03, out = recoded 2.0, flags 0, sqrt 0.
- Both requesters valid every cycle from reset, tags 0x01 / 0x11 -> grants alternate req0, req1, req0, req1. Responses carry matching id and tag in that order.
- Response held with io_resp_ready low for 10 cycles -> outputs stable, no new grant, both io_reqN_ready = 0.
- io_kill 3 cycles into BUSY -> the later result pulse is dropped, io_resp_valid never rises, and the next request is accepted normally.
- Async reset asserted in BUSY mid-cycle -> state IDLE and io_resp_valid = 0 immediately. The pointer favours req0 after release.
- With DIVSQRT_ARB_WATCHDOG_EN, WD_LIMIT = 16, unit stubbed never to respond -> io_wdError rises after 16 BUSY cycles, the FSM returns to IDLE, and io_wdError stays high.

Source files
------------

// File: rtl/divsqrt_rr_arbiter.sv
// Round-robin front end sharing one iterative div/sqrt unit between two FPU issue ports.
// Optional watchdog on stuck operations: define DIVSQRT_ARB_WATCHDOG_EN.
module divsqrt_rr_arbiter #(
  parameter int TAG_W    = 5,
  parameter int WD_LIMIT = 255
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic             io_req0_sqrtOp,
  input  logic [64:0]      io_req0_a,
  input  logic [64:0]      io_req0_b,
  input  logic [2:0]       io_req0_roundingMode,
  input  logic [TAG_W-1:0] io_req0_tag,

  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic             io_req1_sqrtOp,
  input  logic [64:0]      io_req1_a,
  input  logic [64:0]      io_req1_b,
  input  logic [2:0]       io_req1_roundingMode,
  input  logic [TAG_W-1:0] io_req1_tag,

  input  logic             io_du_inReady,
  output logic             io_du_inValid,
  output logic             io_du_sqrtOp,
  output logic [64:0]      io_du_a,
  output logic [64:0]      io_du_b,
  output logic [2:0]       io_du_roundingMode,
  input  logic             io_du_outValid_div,
  input  logic             io_du_outValid_sqrt,
  input  logic [64:0]      io_du_out,
  input  logic [4:0]       io_du_exceptionFlags,

  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic             io_resp_id,
  output logic [TAG_W-1:0] io_resp_tag,
  output logic [64:0]      io_resp_out,
  output logic [4:0]       io_resp_flags,
  output logic             io_resp_sqrt,

  input  logic             io_kill,
  output logic             io_wdError
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;    // requester favoured when both are valid
  logic             id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             drop_q, drop_d;
  logic             capture;
  logic             wd_trip;

  logic             rsp_id_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [64:0]      rsp_out_q;
  logic [4:0]       rsp_flags_q;
  logic             rsp_sqrt_q;

  logic grant;
  logic accept;
  logic pulse;

  always_comb begin
    if (io_req0_valid && io_req1_valid) grant = ptr_q;
    else                                grant = io_req1_valid;
  end

  assign io_du_inValid      = (state_q == IDLE) && (io_req0_valid || io_req1_valid);
  assign io_req0_ready      = io_du_inValid && !grant && io_du_inReady;
  assign io_req1_ready      = io_du_inValid &&  grant && io_du_inReady;
  assign io_du_sqrtOp       = grant ? io_req1_sqrtOp       : io_req0_sqrtOp;
  assign io_du_a            = grant ? io_req1_a            : io_req0_a;
  assign io_du_b            = grant ? io_req1_b            : io_req0_b;
  assign io_du_roundingMode = grant ? io_req1_roundingMode : io_req0_roundingMode;

  assign accept = io_du_inValid && io_du_inReady;
  assign pulse  = io_du_outValid_div || io_du_outValid_sqrt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    tag_d   = tag_q;
    drop_d  = drop_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          id_d    = grant;
          tag_d   = grant ? io_req1_tag : io_req0_tag;
          ptr_d   = ~grant;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (io_kill) drop_d = 1'b1;
        if (pulse) begin
          if (drop_q || io_kill) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (io_resp_ready || io_kill) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A stuck unit is abandoned; its late pulse lands in IDLE and is ignored.
    if (wd_trip) begin
      capture = 1'b0;
      drop_d  = 1'b1;
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      tag_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      rsp_sqrt_q  <= 1'b0;
    end else if (capture) begin
      rsp_id_q    <= id_q;
      rsp_tag_q   <= tag_q;
      rsp_out_q   <= io_du_out;
      rsp_flags_q <= io_du_exceptionFlags;
      rsp_sqrt_q  <= io_du_outValid_sqrt;
    end
  end

  assign io_resp_valid = (state_q == RESP);
  assign io_resp_id    = rsp_id_q;
  assign io_resp_tag   = rsp_tag_q;
  assign io_resp_out   = rsp_out_q;
  assign io_resp_flags = rsp_flags_q;
  assign io_resp_sqrt  = rsp_sqrt_q;

`ifdef DIVSQRT_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(WD_LIMIT + 1) > 8) ? $clog2(WD_LIMIT + 1) : 8;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q;

  // Counter holds (number of BUSY cycles so far - 1); trips in the WD_LIMIT-th BUSY cycle.
  assign wd_trip  = (state_q == BUSY) && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
  assign wd_cnt_d = ((state_q == BUSY) && (state_d == BUSY)) ? wd_cnt_q + WD_W'(1) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_trip) wd_err_q <= 1'b1;
    end
  end

  assign io_wdError = wd_err_q;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = (WD_LIMIT != 0);
  assign wd_trip         = 1'b0;
  assign io_wdError      = 1'b0;
`endif

endmodule

// File: tb/tb_divsqrt_rr_arbiter.sv
// Self-checking bench for divsqrt_rr_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a stub of the shared div/sqrt unit.
module tb_divsqrt_rr_arbiter;
  localparam int TAG_W = 5;
  localparam int WD    = 16;
  localparam logic [64:0] REC_6_0 = {1'b0, 12'h802, 52'h8_0000_0000_0000};
  localparam logic [64:0] REC_3_0 = {1'b0, 12'h801, 52'h8_0000_0000_0000};
  localparam logic [64:0] REC_2_0 = {1'b0, 12'h801, 52'h0};

  typedef struct packed {
    logic             sqrt;
    logic [64:0]      a;
    logic [64:0]      b;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic io_req0_valid, io_req0_ready, io_req0_sqrtOp;
  logic [64:0] io_req0_a, io_req0_b;
  logic [2:0] io_req0_roundingMode;
  logic [TAG_W-1:0] io_req0_tag;
  logic io_req1_valid, io_req1_ready, io_req1_sqrtOp;
  logic [64:0] io_req1_a, io_req1_b;
  logic [2:0] io_req1_roundingMode;
  logic [TAG_W-1:0] io_req1_tag;
  logic io_du_inReady, io_du_inValid, io_du_sqrtOp;
  logic [64:0] io_du_a, io_du_b, io_du_out;
  logic [2:0] io_du_roundingMode;
  logic io_du_outValid_div, io_du_outValid_sqrt;
  logic [4:0] io_du_exceptionFlags;
  logic io_resp_valid, io_resp_ready, io_resp_id, io_resp_sqrt;
  logic [TAG_W-1:0] io_resp_tag;
  logic [64:0] io_resp_out;
  logic [4:0] io_resp_flags;
  logic io_kill, io_wdError;

  always #5 clk = ~clk;

  divsqrt_rr_arbiter #(.TAG_W(TAG_W), .WD_LIMIT(WD)) dut (
    .clock(clk), .reset(rst),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready), .io_req0_sqrtOp(io_req0_sqrtOp),
    .io_req0_a(io_req0_a), .io_req0_b(io_req0_b), .io_req0_roundingMode(io_req0_roundingMode),
    .io_req0_tag(io_req0_tag),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready), .io_req1_sqrtOp(io_req1_sqrtOp),
    .io_req1_a(io_req1_a), .io_req1_b(io_req1_b), .io_req1_roundingMode(io_req1_roundingMode),
    .io_req1_tag(io_req1_tag),
    .io_du_inReady(io_du_inReady), .io_du_inValid(io_du_inValid), .io_du_sqrtOp(io_du_sqrtOp),
    .io_du_a(io_du_a), .io_du_b(io_du_b), .io_du_roundingMode(io_du_roundingMode),
    .io_du_outValid_div(io_du_outValid_div), .io_du_outValid_sqrt(io_du_outValid_sqrt),
    .io_du_out(io_du_out), .io_du_exceptionFlags(io_du_exceptionFlags),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready), .io_resp_id(io_resp_id),
    .io_resp_tag(io_resp_tag), .io_resp_out(io_resp_out), .io_resp_flags(io_resp_flags),
    .io_resp_sqrt(io_resp_sqrt), .io_kill(io_kill), .io_wdError(io_wdError)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Environment knobs and requester state.
  op_t              op [2];
  bit               have [2];
  logic [TAG_W-1:0] fixed_tag [2];
  bit               rnd_tags, rnd_flags, kill_once;
  int unsigned      vld_pct, rdy_pct, rr_pct, kill_pct, stray_pct, new_pct, lat_min, lat_max;

  // Stub of the shared unit: one operation, pulse after a chosen latency.
  int         stub_cnt;
  op_t        stub_op;
  logic [4:0] stub_flags;

  // Reference model: transaction-level ownership of the unit and the held response.
  bit               busy, held, drop_pend;
  logic             last_g;
  logic             in_id;
  logic [TAG_W-1:0] in_tag;
  logic             exp_id, exp_sqrt;
  logic [TAG_W-1:0] exp_tag;
  logic [64:0]      exp_out;
  logic [4:0]       exp_flags;
  int               n_accept, n_resp, n_drop, n_inv;
  logic             grant_log [$];
  logic             resp_id_log [$];
  logic [TAG_W-1:0] resp_tag_log [$];
  logic [64:0]      last_out;

  function automatic logic [64:0] unit_result(input op_t o);
    if (!o.sqrt && o.a == REC_6_0 && o.b == REC_3_0) return REC_2_0;
    return o.sqrt ? ~o.a : (o.a ^ {o.b[31:0], o.b[64:32]});
  endfunction

  function automatic op_t rand_op(input int i);
    op_t o;
    o.sqrt = 1'($urandom());
    o.a    = {1'($urandom()), $urandom(), $urandom()};
    o.b    = {1'($urandom()), $urandom(), $urandom()};
    o.rm   = 3'($urandom());
    o.tag  = rnd_tags ? TAG_W'($urandom()) : fixed_tag[i];
    return o;
  endfunction

  task automatic set_knobs(input int unsigned vld, rdy, rr, kill, stray, newp, lmin, lmax);
    vld_pct = vld; rdy_pct = rdy; rr_pct = rr; kill_pct = kill;
    stray_pct = stray; new_pct = newp; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic model_reset();
    busy = 1'b0; held = 1'b0; drop_pend = 1'b0; last_g = 1'b1; kill_once = 1'b0;
    stub_cnt = -1; have[0] = 1'b0; have[1] = 1'b0;
    n_accept = 0; n_resp = 0; n_drop = 0; n_inv = 0;
    grant_log.delete(); resp_id_log.delete(); resp_tag_log.delete();
  endtask

  task automatic drive_idle();
    io_req0_valid = 1'b0; io_req1_valid = 1'b0;
    io_du_inReady = 1'b1; io_resp_ready = 1'b0; io_kill = 1'b0;
    io_du_outValid_div = 1'b0; io_du_outValid_sqrt = 1'b0;
    io_du_out = '0; io_du_exceptionFlags = '0;
  endtask

  task automatic drive_ops();
    io_req0_sqrtOp = op[0].sqrt; io_req0_a = op[0].a; io_req0_b = op[0].b;
    io_req0_roundingMode = op[0].rm; io_req0_tag = op[0].tag;
    io_req1_sqrtOp = op[1].sqrt; io_req1_a = op[1].a; io_req1_b = op[1].b;
    io_req1_roundingMode = op[1].rm; io_req1_tag = op[1].tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    check("rst_resp_valid", 128'(io_resp_valid), 128'(0));
    check("rst_resp_fields", 128'({io_resp_id, io_resp_tag, io_resp_sqrt, io_resp_flags, io_resp_out}), 128'(0));
    check("rst_wdError", 128'(io_wdError), 128'(0));
    check("rst_idle_outputs", 128'({io_du_inValid, io_req0_ready, io_req1_ready}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, let outputs settle, compare against the model, advance the model.
  task automatic cycle();
    logic v0, v1, g, pulse, stray, exp_inv;
    for (int i = 0; i < 2; i++)
      if (!have[i] && $urandom_range(99) < new_pct) begin
        op[i] = rand_op(i);
        have[i] = 1'b1;
      end
    v0 = have[0] && ($urandom_range(99) < vld_pct);
    v1 = have[1] && ($urandom_range(99) < vld_pct);
    io_req0_valid = v0;
    io_req1_valid = v1;
    drive_ops();
    io_du_inReady = ($urandom_range(99) < rdy_pct);
    io_resp_ready = ($urandom_range(99) < rr_pct);
    io_kill       = kill_once || ($urandom_range(99) < kill_pct);
    kill_once     = 1'b0;
    pulse = (stub_cnt == 0);
    stray = (stub_cnt < 0) && ($urandom_range(99) < stray_pct);
    io_du_outValid_div   = pulse ? !stub_op.sqrt : (stray && 1'($urandom()));
    io_du_outValid_sqrt  = pulse ?  stub_op.sqrt : (stray && !io_du_outValid_div);
    io_du_out            = pulse ? unit_result(stub_op) : {1'($urandom()), $urandom(), $urandom()};
    io_du_exceptionFlags = pulse ? stub_flags : 5'($urandom());
    #1;

    g       = (v0 && v1) ? ~last_g : v1;
    exp_inv = !busy && (v0 || v1);
    check("du_inValid", 128'(io_du_inValid), 128'(exp_inv));
    check("req0_ready", 128'(io_req0_ready), 128'(exp_inv && !g && io_du_inReady));
    check("req1_ready", 128'(io_req1_ready), 128'(exp_inv &&  g && io_du_inReady));
    if (exp_inv) begin
      check("du_op_a", 128'({io_du_sqrtOp, io_du_roundingMode, io_du_a}), 128'({op[g].sqrt, op[g].rm, op[g].a}));
      check("du_op_b", 128'(io_du_b), 128'(op[g].b));
    end
    check("resp_valid", 128'(io_resp_valid), 128'(held));
    if (held)
      check("resp_fields", 128'({io_resp_id, io_resp_tag, io_resp_sqrt, io_resp_flags, io_resp_out}),
            128'({exp_id, exp_tag, exp_sqrt, exp_flags, exp_out}));
    check("wdError", 128'(io_wdError), 128'(0));

    if (io_du_inValid) n_inv++;
    if ((io_req0_ready && v0) || (io_req1_ready && v1)) grant_log.push_back(io_req1_ready && v1);
    if (io_resp_valid && io_resp_ready) begin
      resp_id_log.push_back(io_resp_id);
      resp_tag_log.push_back(io_resp_tag);
      last_out = io_resp_out;
    end

    if (exp_inv && io_du_inReady) begin
      busy = 1'b1; last_g = g; in_id = g; in_tag = op[g].tag; have[g] = 1'b0;
      stub_op = op[g];
      stub_flags = rnd_flags ? 5'($urandom()) : 5'd0;
      stub_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
      n_accept++;
    end else if (busy && !held) begin
      if (pulse) begin
        stub_cnt = -1;
        if (drop_pend || io_kill) begin
          busy = 1'b0; drop_pend = 1'b0; n_drop++;
        end else begin
          held = 1'b1; exp_id = in_id; exp_tag = in_tag; exp_sqrt = stub_op.sqrt;
          exp_out = unit_result(stub_op); exp_flags = stub_flags;
        end
      end else begin
        if (io_kill) drop_pend = 1'b1;
        if (stub_cnt > 0) stub_cnt--;
      end
    end else if (held && (io_resp_ready || io_kill)) begin
      held = 1'b0; busy = 1'b0;
      if (io_resp_ready) n_resp++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [64:0] saved_out;
    int          ng;
    fixed_tag[0] = 5'h01; fixed_tag[1] = 5'h11;
    rnd_tags = 1'b1; rnd_flags = 1'b1;
    op[0] = '0; op[1] = '0;
    drive_ops();
    model_reset();
    do_reset();

    // req0 alone: 6.0 / 3.0, tag 0x03.
    rnd_flags = 1'b0;
    set_knobs(100, 100, 100, 0, 0, 0, 4, 4);
    op[0] = '{sqrt: 1'b0, a: REC_6_0, b: REC_3_0, rm: 3'd0, tag: 5'h03};
    have[0] = 1'b1;
    for (int i = 0; i < 30 && n_resp < 1; i++) cycle();
    check("t1_resp_count", 128'(resp_id_log.size()), 128'(1));
    check("t1_inValid_cycles", 128'(n_inv), 128'(1));
    check("t1_out", 128'(last_out), 128'(REC_2_0));
    check("t1_id_tag", 128'({resp_id_log[0], resp_tag_log[0]}), 128'({1'b0, 5'h03}));

    // Both requesters valid every cycle: grants and responses alternate.
    do_reset();
    rnd_tags = 1'b0;
    set_knobs(100, 100, 100, 0, 0, 100, 2, 2);
    for (int i = 0; i < 100 && resp_id_log.size() < 4; i++) cycle();
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_order", 128'(grant_log[k]), 128'(k % 2));
      check("t2_resp_id", 128'(resp_id_log[k]), 128'(k % 2));
      check("t2_resp_tag", 128'(resp_tag_log[k]), 128'((k % 2) ? 5'h11 : 5'h01));
    end

    // Held response with resp_ready low for 10 cycles.
    do_reset();
    set_knobs(100, 100, 0, 0, 0, 100, 3, 3);
    for (int i = 0; i < 20 && !io_resp_valid; i++) cycle();
    check("t3_resp_up", 128'(io_resp_valid), 128'(1));
    saved_out = io_resp_out;
    ng = grant_log.size();
    repeat (10) cycle();
    check("t3_no_grant", 128'(grant_log.size() - ng), 128'(0));
    check("t3_stable", 128'(io_resp_out), 128'(saved_out));
    rr_pct = 100;
    for (int i = 0; i < 10 && resp_id_log.size() < 1; i++) cycle();
    check("t3_released", 128'(resp_id_log.size()), 128'(1));

    // Kill three cycles into BUSY drops the later pulse.
    do_reset();
    rnd_tags = 1'b1; rnd_flags = 1'b1;
    set_knobs(100, 100, 100, 0, 0, 0, 8, 8);
    op[0] = rand_op(0); have[0] = 1'b1;
    for (int i = 0; i < 10 && n_accept < 1; i++) cycle();
    cycle(); cycle();
    kill_once = 1'b1;
    cycle();
    for (int i = 0; i < 20 && n_drop < 1; i++) cycle();
    check("t4_dropped", 128'(n_drop), 128'(1));
    check("t4_no_resp", 128'(resp_id_log.size()), 128'(0));
    op[1] = rand_op(1); have[1] = 1'b1;
    for (int i = 0; i < 30 && resp_id_log.size() < 1; i++) cycle();
    check("t4_next_ok", 128'(resp_id_log.size()), 128'(1));
    check("t4_next_id", 128'(resp_id_log[0]), 128'(1));

    // Asynchronous reset in the middle of a BUSY cycle.
    set_knobs(100, 100, 100, 0, 0, 0, 10, 10);
    op[1] = rand_op(1); have[1] = 1'b1;
    for (int i = 0; i < 10 && n_accept < 2; i++) cycle();
    cycle(); cycle();
    #3;
    rst = 1'b1;
    drive_idle();
    op[0] = rand_op(0); op[1] = rand_op(1);
    drive_ops();
    io_req0_valid = 1'b1; io_req1_valid = 1'b1;
    #1;
    check("t5_resp_valid", 128'(io_resp_valid), 128'(0));
    check("t5_idle_grant0", 128'({io_du_inValid, io_req0_ready, io_req1_ready}), 128'(3'b110));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    have[0] = 1'b1; have[1] = 1'b1;
    for (int i = 0; i < 10 && grant_log.size() < 1; i++) cycle();
    check("t5_ptr_req0", 128'(grant_log[0]), 128'(0));

    // Randomized traffic: backpressure, kills, stray pulses.
    do_reset();
    set_knobs(70, 80, 60, 5, 10, 50, 1, 6);
    repeat (3000) cycle();
    check("rand_progress", 128'(n_resp > 50), 128'(1));

`ifdef DIVSQRT_ARB_WATCHDOG_EN
    // Unit never responds: watchdog trips after WD BUSY cycles and stays set.
    do_reset();
    set_knobs(100, 100, 100, 0, 0, 0, 1000, 1000);
    op[0] = rand_op(0); have[0] = 1'b1;
    for (int i = 0; i < 10 && n_accept < 1; i++) cycle();
    drive_idle();
    for (int i = 1; i < WD; i++) begin @(posedge clk); #1; end
    check("wd_before_limit", 128'(io_wdError), 128'(0));
    @(posedge clk); #1;
    check("wd_set", 128'(io_wdError), 128'(1));
    io_req0_valid = 1'b1;
    #1;
    check("wd_back_idle", 128'(io_du_inValid), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    check("wd_sticky", 128'(io_wdError), 128'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
